// File: rtl/fp16_mul_pipe.sv
// fp16_mul_pipe: three-stage valid/ready IEEE-754 binary16 multiplier.
// Stages: S1 unpack/multiply, S2 normalize (guard/round/sticky), S3 round-to-nearest-even/pack.
// Subnormal inputs are treated as zero and subnormal results flush to signed zero.
// Optional feature: define FP16_MUL_FLAGS_EN to add flags[3:0] = {invalid, overflow, underflow, inexact}.
module fp16_mul_pipe #(
  parameter logic [15:0] NAN_CANON = 16'h7E00,
  parameter bit          FTZ       = 1'b1   // 1: subnormal operands read as zero, subnormal results flush to signed zero
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
`ifdef FP16_MUL_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  typedef enum logic [1:0] {SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3} spec_t;

  // The whole pipe moves together; it only freezes when the output is held.
  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- S1: unpack, classify, multiply ----------------
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  spec_t              s1_spec_next;
  logic signed [6:0]  s1_exp_next;
  logic [21:0]        s1_frac_next;

  logic               s1_valid, s1_sign;
  spec_t              s1_spec;
  logic signed [6:0]  s1_exp;
  logic [21:0]        s1_frac;
`ifdef FP16_MUL_FLAGS_EN
  logic               s1_inv_next, s1_inv;
`endif

  // Classify operands, compute the biased exponent sum and the full significand product.
  always_comb begin
    a_zero = (a[14:10] == 5'd0) && (FTZ || (a[9:0] == 10'd0));
    b_zero = (b[14:10] == 5'd0) && (FTZ || (b[9:0] == 10'd0));
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    s1_spec_next = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      s1_spec_next = SP_NAN;
    else if (a_inf || b_inf)
      s1_spec_next = SP_INF;
    else if (a_zero || b_zero)
      s1_spec_next = SP_ZERO;
    s1_exp_next  = $signed({2'b00, a[14:10]}) + $signed({2'b00, b[14:10]}) - 7'sd15;
    s1_frac_next = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
`ifdef FP16_MUL_FLAGS_EN
    // Invalid: inf x zero, or a signaling NaN operand (quiet bit clear).
    s1_inv_next = (a_inf && b_zero) || (b_inf && a_zero) ||
                  (a_nan && !a[9]) || (b_nan && !b[9]);
`endif
  end

  // S1 register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_spec  <= SP_NONE;
      s1_exp   <= 7'sd0;
      s1_frac  <= 22'd0;
`ifdef FP16_MUL_FLAGS_EN
      s1_inv   <= 1'b0;
`endif
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= a[15] ^ b[15];
      s1_spec  <= s1_spec_next;
      s1_exp   <= s1_exp_next;
      s1_frac  <= s1_frac_next;
`ifdef FP16_MUL_FLAGS_EN
      s1_inv   <= s1_inv_next;
`endif
    end
  end

  // ---------------- S2: normalize to 1.xxx with guard/round/sticky ----------------
  logic [9:0]         s2_mant_next;
  logic               s2_g_next, s2_r_next, s2_s_next;
  logic signed [6:0]  s2_exp_next;

  logic               s2_valid, s2_sign, s2_g, s2_r, s2_s;
  spec_t              s2_spec;
  logic [9:0]         s2_mant;
  logic signed [6:0]  s2_exp;
`ifdef FP16_MUL_FLAGS_EN
  logic               s2_inv;
`endif

  // Product of two 1.x significands lies in [1,4); a set bit 21 means it is >= 2.
  always_comb begin
    if (s1_frac[21]) begin
      s2_mant_next = s1_frac[20:11];
      s2_g_next    = s1_frac[10];
      s2_r_next    = s1_frac[9];
      s2_s_next    = |s1_frac[8:0];
      s2_exp_next  = s1_exp + 7'sd1;
    end else begin
      s2_mant_next = s1_frac[19:10];
      s2_g_next    = s1_frac[9];
      s2_r_next    = s1_frac[8];
      s2_s_next    = |s1_frac[7:0];
      s2_exp_next  = s1_exp;
    end
  end

  // S2 register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_spec  <= SP_NONE;
      s2_mant  <= 10'd0;
      s2_g     <= 1'b0;
      s2_r     <= 1'b0;
      s2_s     <= 1'b0;
      s2_exp   <= 7'sd0;
`ifdef FP16_MUL_FLAGS_EN
      s2_inv   <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_spec  <= s1_spec;
      s2_mant  <= s2_mant_next;
      s2_g     <= s2_g_next;
      s2_r     <= s2_r_next;
      s2_s     <= s2_s_next;
      s2_exp   <= s2_exp_next;
`ifdef FP16_MUL_FLAGS_EN
      s2_inv   <= s1_inv;
`endif
    end
  end

  // ---------------- S3: round, range-check, pack ----------------
  logic               inc;
  logic [10:0]        mant_rnd;
  logic signed [6:0]  exp_fin;
  logic [15:0]        res_next;
`ifdef FP16_MUL_FLAGS_EN
  logic               ovf, unf, inx;
`endif

  // Round-to-nearest-even; a mantissa carry-out wraps to zero and bumps the exponent.
  always_comb begin
    inc      = s2_g & (s2_r | s2_s | s2_mant[0]);
    mant_rnd = {1'b0, s2_mant} + {10'd0, inc};
    exp_fin  = s2_exp + (mant_rnd[10] ? 7'sd1 : 7'sd0);
    res_next = {s2_sign, exp_fin[4:0], mant_rnd[9:0]};
`ifdef FP16_MUL_FLAGS_EN
    ovf = 1'b0;
    unf = 1'b0;
    inx = 1'b0;
`endif
    case (s2_spec)
      SP_NAN:  res_next = NAN_CANON;
      SP_INF:  res_next = {s2_sign, 5'h1F, 10'd0};
      SP_ZERO: res_next = {s2_sign, 15'd0};
      default: begin
`ifdef FP16_MUL_FLAGS_EN
        inx = s2_g | s2_r | s2_s;
`endif
        if (exp_fin >= 7'sd31) begin
          res_next = {s2_sign, 5'h1F, 10'd0};
`ifdef FP16_MUL_FLAGS_EN
          ovf = 1'b1;
          inx = 1'b1;
`endif
        end else if (exp_fin <= 7'sd0) begin
          res_next = {s2_sign, 15'd0};
`ifdef FP16_MUL_FLAGS_EN
          unf = 1'b1;
          inx = 1'b1;
`endif
        end
      end
    endcase
  end

  // Output register: result and flags are held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 16'h0000;
`ifdef FP16_MUL_FLAGS_EN
      flags     <= 4'd0;
`endif
    end else if (advance) begin
      out_valid <= s2_valid;
      result    <= res_next;
`ifdef FP16_MUL_FLAGS_EN
      flags     <= {s2_inv, ovf, unf, inx};
`endif
    end
  end

endmodule
